// File: rtl/port_bus_pkg.sv
// rtl/port_bus_pkg.sv - shared types for the port bus master (FSM states, opcodes, command word)
package port_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_STROBE   = 3'd2,
      ST_RESP     = 3'd3,
      ST_IRQ_ACK  = 3'd4,
      ST_IRQ_WAIT = 3'd5
   } state_t;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   typedef struct packed {
      logic       write;
      logic [7:0] port;
      logic [7:0] data;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/port_cmd_fifo.sv
// rtl/port_cmd_fifo.sv - synchronous command FIFO, registered read pointer, no write-to-read bypass
module port_cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 17,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LW-1:0]    o_level
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_level == DEPTH_L);
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Storage array: written on accepted push, contents need no reset
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally (power-of-two depth); level tracks occupancy
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/port_bus_master.sv
// rtl/port_bus_master.sv - port bus initiator: queued INPUT/OUTPUT cycles, read responses, IRQ ack (PORT_MASTER_IRQ_EN)
module port_bus_master
   import port_bus_pkg::*;
#(
   parameter  int CMD_DEPTH = 4,
   localparam int LW        = $clog2(CMD_DEPTH) + 1
) (
   input  logic          i_sysclk,
   input  logic          i_sysreset,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_write,
   input  logic [7:0]    i_cmd_port,
   input  logic [7:0]    i_cmd_data,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [7:0]    o_rsp_port,
   output logic [7:0]    o_rsp_data,
   output logic [7:0]    o_port_id,
   output logic [7:0]    o_out_port,
   output logic          o_write_strobe,
   output logic          o_read_strobe,
   input  logic [7:0]    i_in_port,
   input  logic          i_interrupt,
   output logic          o_interrupt_ack,
   output logic          o_irq_event,
   output logic          o_busy,
   output logic [LW-1:0] o_fifo_level
);

   state_t      r_state;
   logic        r_run;
   logic        r_cur_write;
   logic [7:0]  r_port_id;
   logic [7:0]  r_out_port;
   logic        r_write_strobe;
   logic        r_read_strobe;
   logic        r_rsp_valid;
   logic [7:0]  r_rsp_port;
   logic [7:0]  r_rsp_data;

   cmd_t        w_cmd_in;
   cmd_t        w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_irq_req;

`ifdef PORT_MASTER_IRQ_EN
   logic        r_int_ack;
   logic        r_irq_event;

   assign w_irq_req       = i_interrupt;
   assign o_interrupt_ack = r_int_ack;
   assign o_irq_event     = r_irq_event;
`else
   logic        w_unused_irq;

   assign w_unused_irq    = i_interrupt;
   assign w_irq_req       = 1'b0;
   assign o_interrupt_ack = 1'b0;
   assign o_irq_event     = 1'b0;
`endif

   // r_run keeps cmd_ready low while reset is held and for the release cycle
   assign o_cmd_ready = r_run & ~w_full;
   assign w_push      = i_cmd_valid & o_cmd_ready;
   assign w_pop       = (r_state == ST_IDLE) & ~w_empty & ~w_irq_req;
   assign w_cmd_in    = {i_cmd_write, i_cmd_port, i_cmd_data};

   assign o_busy         = (r_state != ST_IDLE) | ~w_empty;
   assign o_port_id      = r_port_id;
   assign o_out_port     = r_out_port;
   assign o_write_strobe = r_write_strobe;
   assign o_read_strobe  = r_read_strobe;
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_port     = r_rsp_port;
   assign o_rsp_data     = r_rsp_data;

   port_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .i_clk   (i_sysclk),
      .i_rst_n (i_sysreset),
      .i_push  (w_push),
      .i_wdata (w_cmd_in),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );

   // Bus sequencer: every output is a register set on the transition into the state that owns it
   always_ff @(posedge i_sysclk or negedge i_sysreset) begin
      if (!i_sysreset) begin
         r_state        <= ST_IDLE;
         r_run          <= 1'b0;
         r_cur_write    <= 1'b0;
         r_port_id      <= '0;
         r_out_port     <= '0;
         r_write_strobe <= 1'b0;
         r_read_strobe  <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_port     <= '0;
         r_rsp_data     <= '0;
`ifdef PORT_MASTER_IRQ_EN
         r_int_ack      <= 1'b0;
         r_irq_event    <= 1'b0;
`endif
      end else begin
         r_run          <= 1'b1;
         r_write_strobe <= 1'b0;
         r_read_strobe  <= 1'b0;
`ifdef PORT_MASTER_IRQ_EN
         r_int_ack      <= 1'b0;
         r_irq_event    <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
`ifdef PORT_MASTER_IRQ_EN
               if (i_interrupt) begin
                  r_int_ack   <= 1'b1;
                  r_irq_event <= 1'b1;
                  r_state     <= ST_IRQ_ACK;
               end else
`endif
               if (!w_empty) begin
                  r_cur_write <= w_head.write;
                  r_port_id   <= w_head.port;
                  if (w_head.write == CMD_WR) begin
                     r_out_port <= w_head.data;
                  end
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (r_cur_write == CMD_WR) begin
                  r_write_strobe <= 1'b1;
               end else begin
                  r_read_strobe <= 1'b1;
               end
               r_state <= ST_STROBE;
            end
            ST_STROBE: begin
               if (r_cur_write == CMD_RD) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_port  <= r_port_id;
                  r_rsp_data  <= i_in_port;
                  r_state     <= ST_RESP;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
`ifdef PORT_MASTER_IRQ_EN
            ST_IRQ_ACK: begin
               r_state <= ST_IRQ_WAIT;
            end
            ST_IRQ_WAIT: begin
               if (!i_interrupt) begin
                  r_state <= ST_IDLE;
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_bus_master.sv
// tb/tb_port_bus_master.sv - self-checking bench for port_bus_master with transaction-level reference model
module tb_port_bus_master;

   localparam int DEPTH = 4;
   localparam int LW    = 3;

   typedef struct {
      bit         w;
      logic [7:0] p;
      logic [7:0] d;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [7:0]    cmd_port;
   logic [7:0]    cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_port;
   logic [7:0]    rsp_data;
   logic [7:0]    port_id;
   logic [7:0]    out_port;
   logic          write_strobe;
   logic          read_strobe;
   logic [7:0]    in_port;
   logic          interrupt;
   logic          interrupt_ack;
   logic          irq_event;
   logic          busy;
   logic [LW-1:0] fifo_level;

   int n_checks = 0;
   int n_pass   = 0;
   int rsp_mode = 0;
   int n_ws = 0, n_rs = 0, n_ack = 0, n_evt = 0;

   logic [7:0] resp_mem  [256];
   logic [7:0] model_mem [256];
   ev_t        exp_bus [$];
   ev_t        exp_rsp [$];

   always #5 clk = ~clk;

   port_bus_master #(.CMD_DEPTH(DEPTH)) dut (
      .i_sysclk        (clk),
      .i_sysreset      (rst_n),
      .i_cmd_valid     (cmd_valid),
      .o_cmd_ready     (cmd_ready),
      .i_cmd_write     (cmd_write),
      .i_cmd_port      (cmd_port),
      .i_cmd_data      (cmd_data),
      .o_rsp_valid     (rsp_valid),
      .i_rsp_ready     (rsp_ready),
      .o_rsp_port      (rsp_port),
      .o_rsp_data      (rsp_data),
      .o_port_id       (port_id),
      .o_out_port      (out_port),
      .o_write_strobe  (write_strobe),
      .o_read_strobe   (read_strobe),
      .i_in_port       (in_port),
      .i_interrupt     (interrupt),
      .o_interrupt_ack (interrupt_ack),
      .o_irq_event     (irq_event),
      .o_busy          (busy),
      .o_fifo_level    (fifo_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Responder: register file with registered read mux
   initial begin
      for (int i = 0; i < 256; i++) begin
         resp_mem[i] <= 8'(i) ^ 8'h36;
      end
   end

   always @(posedge clk) begin
      if (write_strobe) begin
         resp_mem[port_id] <= out_port;
      end
      in_port <= resp_mem[port_id];
   end

   // Monitor: drive rsp_ready for the coming edge, then score bus cycles and responses
   always @(negedge clk) begin
      ev_t e;
      case (rsp_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = 1'($urandom_range(0, 1));
         default: rsp_ready = 1'b0;
      endcase
      if (rst_n) begin
         if (write_strobe || read_strobe) begin
            chk("strobe_excl", 32'(write_strobe & read_strobe), 0);
            if (exp_bus.size() == 0) begin
               chk("bus_unexpected", {30'd0, write_strobe, read_strobe}, 0);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_dir", 32'(write_strobe), 32'(e.w));
               chk("bus_port", 32'(port_id), 32'(e.p));
               if (e.w) begin
                  chk("bus_wdata", 32'(out_port), 32'(e.d));
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
               e = exp_rsp.pop_front();
               chk("rsp_port", 32'(rsp_port), 32'(e.p));
               chk("rsp_data", 32'(rsp_data), 32'(e.d));
            end
         end
         n_ws  += int'(write_strobe);
         n_rs  += int'(read_strobe);
         n_ack += int'(interrupt_ack);
         n_evt += int'(irq_event);
      end
   end

   // Offer one command; model is updated when the handshake edge is reached
   task automatic send_cmd(input bit w, input logic [7:0] p, input logic [7:0] d);
      int  n = 0;
      ev_t e;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_port  = p;
      cmd_data  = d;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept_tmo", 32'(n < 100), 1);
      if (n < 100) begin
         @(posedge clk);
         e.w = w;
         e.p = p;
         e.d = d;
         exp_bus.push_back(e);
         if (w) begin
            model_mem[p] = d;
         end else begin
            e.d = model_mem[p];
            exp_rsp.push_back(e);
         end
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || exp_bus.size() != 0 || exp_rsp.size() != 0) && n < 400);
      chk(tag, 32'(n < 400), 1);
   endtask

   initial begin
      int         n;
      int         a0, e0, s0;
      logic [7:0] hold_data;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_port  = '0;
      cmd_data  = '0;
      interrupt = 1'b0;
      for (int i = 0; i < 256; i++) begin
         model_mem[i] = 8'(i) ^ 8'h36;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_strobes", {30'd0, write_strobe, read_strobe}, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_port_id", 32'(port_id), 0);
      chk("rst_ack", {30'd0, interrupt_ack, irq_event}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_cmd_ready", 32'(cmd_ready), 1);

      // Single write, cycle-accurate
      send_cmd(1'b1, 8'h02, 8'hA5);
      @(negedge clk);
      chk("wr_e0_level", 32'(fifo_level), 1);
      chk("wr_e0_busy", 32'(busy), 1);
      @(negedge clk);
      chk("wr_e1_port_id", 32'(port_id), 32'h02);
      chk("wr_e1_ws", 32'(write_strobe), 0);
      @(negedge clk);
      chk("wr_e2_ws", 32'(write_strobe), 1);
      chk("wr_e2_out_port", 32'(out_port), 32'hA5);
      @(negedge clk);
      chk("wr_e3_ws", 32'(write_strobe), 0);
      chk("wr_e3_busy", 32'(busy), 0);

      // Single read, cycle-accurate
      send_cmd(1'b0, 8'h0A, 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("rd_e1_port_id", 32'(port_id), 32'h0A);
      chk("rd_e1_rs", 32'(read_strobe), 0);
      @(negedge clk);
      chk("rd_e2_rs", 32'(read_strobe), 1);
      chk("rd_e2_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("rd_e3_rsp_valid", 32'(rsp_valid), 1);
      chk("rd_e3_rsp_data", 32'(rsp_data), 32'h3C);
      chk("rd_e3_rsp_port", 32'(rsp_port), 32'h0A);
      @(negedge clk);
      chk("rd_e4_rsp_valid", 32'(rsp_valid), 0);
      chk("rd_e4_rsp_hold", 32'(rsp_data), 32'h3C);

      // Stalled response: FIFO fills, bus frozen, response held stable
      rsp_mode = 2;
      send_cmd(1'b0, 8'h05, 8'h00);
      hold_data = model_mem[8'h05];
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_tmo", 32'(n < 20), 1);
      for (int k = 0; k < DEPTH; k++) begin
         send_cmd(1'b1, 8'(8'h20 + k), 8'($urandom));
      end
      @(negedge clk);
      chk("full_level", 32'(fifo_level), DEPTH);
      chk("full_ready", 32'(cmd_ready), 0);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_port  = 8'h30;
      cmd_data  = 8'h77;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_ready", 32'(cmd_ready), 0);
         chk("hold_level", 32'(fifo_level), DEPTH);
         chk("hold_rsp_valid", 32'(rsp_valid), 1);
         chk("hold_rsp_data", 32'(rsp_data), 32'(hold_data));
         chk("hold_strobes", {30'd0, write_strobe, read_strobe}, 0);
      end
      rsp_mode = 0;
      send_cmd(1'b1, 8'h30, 8'h77);
      wait_drain("drain_stall");

      // Interrupt while a command is queued
      @(negedge clk);
      interrupt = 1'b1;
      a0 = n_ack;
      e0 = n_evt;
      s0 = n_ws;
      send_cmd(1'b1, 8'h40, 8'h99);
      repeat (8) @(negedge clk);
`ifdef PORT_MASTER_IRQ_EN
      chk("irq_ack_count", 32'(n_ack - a0), 1);
      chk("irq_event_count", 32'(n_evt - e0), 1);
      chk("irq_blocks_bus", 32'(n_ws - s0), 0);
      interrupt = 1'b0;
      repeat (8) @(negedge clk);
      chk("irq_resume_ws", 32'(n_ws - s0), 1);
      chk("irq_no_double_ack", 32'(n_ack - a0), 1);
`else
      chk("irq_ack_tied", 32'(n_ack - a0), 0);
      chk("irq_event_tied", 32'(n_evt - e0), 0);
      chk("irq_ignored_ws", 32'(n_ws - s0), 1);
      interrupt = 1'b0;
`endif
      wait_drain("drain_irq");

      // Reset during a write strobe
      send_cmd(1'b1, 8'hF0, 8'h11);
      send_cmd(1'b1, 8'hF1, 8'h22);
      send_cmd(1'b1, 8'hF2, 8'h33);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!write_strobe && n < 20);
      chk("mid_rst_strobe_tmo", 32'(n < 20), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ws", 32'(write_strobe), 0);
      chk("mid_rst_rs", 32'(read_strobe), 0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_level", 32'(fifo_level), 0);
      exp_bus.delete();
      exp_rsp.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_level", 32'(fifo_level), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_ready", 32'(cmd_ready), 1);
      for (int i = 0; i < 256; i++) begin
         model_mem[i] = resp_mem[i];
      end

      // Randomized traffic with random response back-pressure
      rsp_mode = 1;
      for (int k = 0; k < 60; k++) begin
         send_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
      end
      wait_drain("drain_random");
      chk("final_bus_q", 32'(exp_bus.size()), 0);
      chk("final_rsp_q", 32'(exp_rsp.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
